systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Job sequencer for the skew-buffered `systolic_core`. It loads one N×N weight tile into the core, then streams M activation rows into it through ready/valid handshakes. It collects the M aligned result rows and signals completion. It sits between the activation/weight buffers and the core, and owns every core control input.

## Interface
Parameters:
- `N`, 8, array dimension (rows = columns)
- `DATA_WIDTH`, 8, activation/weight element width
- `ACC_WIDTH`, 32, accumulator/result element width
- `CNT_WIDTH`, 16, width of row count `num_rows`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  job request, sampled only in IDLE
- `num_rows`  in  CNT_WIDTH  activation rows M, latched on accepted `start`
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse on job completion
- `err`  out  1  sticky column-misalignment flag; cleared by accepted `start`
- `w_valid` / `w_ready`  in / out  1 / 1  weight-row handshake
- `w_data`  in  N*DATA_WIDTH  one weight row
- `a_valid` / `a_ready`  in / out  1 / 1  activation-row handshake
- `a_data`  in  N*DATA_WIDTH  one activation row
- `core_load_weight`  out  1  to core `load_weight`
- `core_valid_in`  out  N  to core `valid_in`
- `core_x_in`  out  N*DATA_WIDTH  to core `x_in`
- `core_y_in`  out  N*ACC_WIDTH  to core `y_in`; constant 0
- `core_y_out`  in  N*ACC_WIDTH  from core `y_out`
- `core_valid_out`  in  N  from core `valid_out`
- `res_valid`  out  1  result row valid; no backpressure
- `res_data`  out  N*ACC_WIDTH  result row

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- **IDLE:**
  - `start`=1 latches `num_rows`, clears counters and `err`, and moves to LOAD_W.
  - `start` in any other state is ignored.
- **LOAD_W:**
  - `w_ready`=1.
  - Each `w_valid&w_ready` beat drives `core_load_weight`=1 and `core_x_in`=`w_data` in the same cycle, and increments `w_cnt`.
  - On the Nth beat the block moves to STREAM if M>0, else to DONE. M=0 is the weight-preload-only job.
- **STREAM:**
  - `a_ready`=1 while `in_cnt`<M.
  - A handshake drives `core_valid_in`={N{1}} and `core_x_in`=`a_data`, and increments `in_cnt`.
  - No handshake (bubble) drives `core_valid_in`=0 and `core_x_in`=0.
  - The block moves to DRAIN on the cycle the Mth row is accepted.
- **DRAIN:** all core inputs are 0. The block waits until `out_cnt`==M, then moves to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Output capture:**
  - Every cycle, `res_valid` <= &`core_valid_out` and `res_data` <= `core_y_out`.
  - `out_cnt` increments on `res_valid`. This is active in STREAM and DRAIN.
- **Misalignment:** if `core_valid_out` is neither all-0 nor all-1, `err` is set. The job still completes on count.
- **Counter widths:**
  - `in_cnt` and `out_cnt` are CNT_WIDTH.
  - `w_cnt` is $clog2(N+1).
  - M never exceeds 2^CNT_WIDTH−1, so there is no wrap-around.
- **Reset:**
  - Asynchronous reset anywhere returns the block to IDLE, zeroes all counters, and drives every output to 0. This includes `w_ready`, `a_ready`, `done`, `err` and `res_valid`.
  - Rows already inside the core are not flushed. Their results appear as `res_valid` pulses after reset and are ignored, because `out_cnt` counts only in STREAM/DRAIN.

## Timing
- `start` at cycle t gives `busy` and `w_ready` high at t+1.
- Weight beat to `core_load_weight`: combinational, same cycle.
- Activation beat to `core_valid_in`: combinational, same cycle.
- Row accepted at cycle t appears on `res_valid` at t + L_core + 1, where L_core is the core's input-skew + array + de-skew latency.
- Minimum job length with no stalls: 1 + N + M + L_core + 1 + 1 cycles from `start` to `done`.
- `busy` falls the cycle after `done`.
- Back-to-back jobs: `start` is accepted in the first IDLE cycle.

## Configuration
- `SYSTOLIC_CTRL_PERF_EN` defined:
  - Adds outputs `perf_cycles` (32) and `perf_stalls` (32).
  - `perf_cycles` counts cycles with `busy`=1.
  - `perf_stalls` counts STREAM cycles with `in_cnt`<M and `a_valid`=0.
  - Both clear on accepted `start` and hold their value in IDLE.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- `systolic_pkg` holds:
  - the state enum;
  - default N/DATA_WIDTH/ACC_WIDTH/CNT_WIDTH constants;
  - the core latency function L_core(N), shared with the core's testbench.
- One sub-module, `systolic_result_reg`: the registered `res_valid`/`res_data` capture plus the misalignment check.

## Test plan
- N=8, identity weights, M=4 rows of values 1..8, no stalls -> 4 `res_valid` beats, each row echoing its input; `done` at cycle 1+8+4+L_core+2.
- Same job with `a_valid` low on alternate cycles -> identical results with gaps; `done` delayed by 4 cycles; with the macro, `perf_stalls`=4.
- M=0 -> 8 `core_load_weight` beats, then `done`; no `a_ready` and no `res_valid`.
- `start` pulsed during STREAM -> ignored; `num_rows` unchanged; exactly one `done`.
- `rst_n` asserted mid-DRAIN -> all outputs 0 immediately; a new job of M=2 completes with exactly 2 counted rows.
- Force `core_valid_out`=8'h0F for one cycle -> `err`=1 sticky until the next `start`.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the systolic_ctrl job sequencer and
// the systolic_core test environment.
//   - state_t       : sequencer state encoding
//   - DEF_*         : default array / datapath / row-count widths
//   - l_core(n)     : core latency from an accepted row on valid_in to its
//                     aligned result on valid_out/y_out
package systolic_pkg;

    localparam int DEF_N          = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Input skew (n-1) + pass through the n-deep array (n) + output
    // de-skew (n-1).
    function automatic int l_core(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: weight-row and activation-row ready/valid streams
// between the operand buffers and systolic_ctrl.
//   master : buffer side, drives valid/data, receives ready
//   slave  : sequencer side, drives ready
interface systolic_ctrl_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8
);
    logic                    w_valid;
    logic                    w_ready;
    logic [N*DATA_WIDTH-1:0] w_data;
    logic                    a_valid;
    logic                    a_ready;
    logic [N*DATA_WIDTH-1:0] a_data;

    modport master (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready
    );
endinterface

// File: rtl/systolic_result_reg.sv
// systolic_result_reg: registers one result row per cycle from the core and
// flags column misalignment.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr             : clears the sticky error (accepted job start)
//   core_valid_out  : per-column valid from the core
//   core_y_out      : result row from the core
//   res_valid       : all columns valid in the previous cycle
//   res_data        : result row captured in the previous cycle
//   err             : sticky, set when core_valid_out is neither all-0 nor all-1
module systolic_result_reg #(
    parameter int N         = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [N-1:0]         core_valid_out,
    input  logic [N*ACC_WIDTH-1:0] core_y_out,
    output logic                 res_valid,
    output logic [N*ACC_WIDTH-1:0] res_data,
    output logic                 err
);

    logic misaligned;
    assign misaligned = (|core_valid_out) & ~(&core_valid_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            // NOTE: res_data is a pure data register; it is reset only because
            // every output must read 0 while reset is asserted.
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            res_valid <= &core_valid_out;
            res_data  <= core_y_out;
            // A misalignment seen in the same cycle as a clear still sticks.
            err       <= (err & ~clr) | misaligned;
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for the skew-buffered systolic_core.
// Loads an N-row weight tile, streams M activation rows, counts M result
// rows back and pulses done.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, num_rows   : job request (IDLE only) and activation row count M
//   busy, done, err   : status; done is a one-cycle pulse, err is sticky
//   bus (slave)       : weight / activation row streams
//   core_*            : every control/data input of the core, plus its outputs
//   res_valid/res_data: registered result rows, no backpressure
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds perf_cycles / perf_stalls.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    num_rows,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    systolic_ctrl_if.slave          bus,
    output logic                    core_load_weight,
    output logic [N-1:0]            core_valid_in,
    output logic [N*DATA_WIDTH-1:0] core_x_in,
    output logic [N*ACC_WIDTH-1:0]  core_y_in,
    input  logic [N*ACC_WIDTH-1:0]  core_y_out,
    input  logic [N-1:0]            core_valid_out,
    output logic                    res_valid,
    output logic [N*ACC_WIDTH-1:0]  res_data
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_stalls
`endif
);

    localparam int WCW = $clog2(N + 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] m_rows;
    logic [WCW-1:0]       w_cnt;
    logic [CNT_WIDTH-1:0] in_cnt;
    logic [CNT_WIDTH-1:0] out_cnt;

    logic w_fire;
    logic a_fire;
    logic start_acc;

    assign w_fire    = bus.w_valid & bus.w_ready;
    assign a_fire    = bus.a_valid & bus.a_ready;
    assign start_acc = start & (state == ST_IDLE);
    assign core_y_in = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            m_rows      <= '0;
            w_cnt       <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus.w_ready <= 1'b0;
            bus.a_ready <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below reads the
            // pre-edge values of state and the counters.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_rows      <= num_rows;
                        w_cnt       <= '0;
                        in_cnt      <= '0;
                        out_cnt     <= '0;
                        busy        <= 1'b1;
                        bus.w_ready <= 1'b1;
                        state       <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + WCW'(1);
                        if (w_cnt == WCW'(N - 1)) begin
                            bus.w_ready <= 1'b0;
                            // M = 0 is a weight-preload-only job.
                            if (m_rows != '0) begin
                                bus.a_ready <= 1'b1;
                                state       <= ST_STREAM;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_STREAM: begin
                    if (a_fire) begin
                        in_cnt <= in_cnt + CNT_WIDTH'(1);
                        if (in_cnt + CNT_WIDTH'(1) == m_rows) begin
                            bus.a_ready <= 1'b0;
                            state       <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_cnt == m_rows) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    bus.w_ready <= 1'b0;
                    bus.a_ready <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase

            // Results are counted only while a job expects them; rows left in
            // the core across a reset surface while IDLE and are ignored.
            if ((state == ST_STREAM || state == ST_DRAIN) && res_valid)
                out_cnt <= out_cnt + CNT_WIDTH'(1);
        end
    end

    // Core inputs follow the handshake in the same cycle.
    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        core_load_weight = 1'b0;
        core_valid_in    = '0;
        core_x_in        = '0;
        if (state == ST_LOAD_W && w_fire) begin
            core_load_weight = 1'b1;
            core_x_in        = bus.w_data;
        end else if (state == ST_STREAM && a_fire) begin
            core_valid_in = '1;
            core_x_in     = bus.a_data;
        end
    end

    systolic_result_reg #(
        .N         (N),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_result_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (start_acc),
        .core_valid_out (core_valid_out),
        .core_y_out     (core_y_out),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .err            (err)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                perf_cycles <= '0;
                perf_stalls <= '0;
            end
        end else begin
            if (busy)
                perf_cycles <= perf_cycles + 32'd1;
            if (state == ST_STREAM && in_cnt < m_rows && !bus.a_valid)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: self-checking bench for systolic_ctrl with a behavioural
// systolic_core stand-in (fixed latency, real matrix product).
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int CW  = 16;
    localparam int LAT = l_core(N);
    localparam int RW  = N * AW;

    typedef struct {
        int m;
        int wmode;
        bit stall;
        bit glitch;
        int lat;
        int stalls;
    } job_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_rows = '0;
    logic          busy, done, err;
    logic          core_load_weight;
    logic [N-1:0]  core_valid_in;
    logic [N*DW-1:0] core_x_in;
    logic [RW-1:0] core_y_in;
    logic [RW-1:0] core_y_out;
    logic [N-1:0]  core_valid_out;
    logic          res_valid;
    logic [RW-1:0] res_data;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    systolic_ctrl_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    systolic_ctrl #(
        .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .num_rows         (num_rows),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .bus              (bus),
        .core_load_weight (core_load_weight),
        .core_valid_in    (core_valid_in),
        .core_x_in        (core_x_in),
        .core_y_in        (core_y_in),
        .core_y_out       (core_y_out),
        .core_valid_out   (core_valid_out),
        .res_valid        (res_valid),
        .res_data         (res_data)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_cycles      (perf_cycles),
        .perf_stalls      (perf_stalls)
`endif
    );

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- core stand-in: LAT-deep delay + x*W ----------------
    bit            core_clr = 1'b1;
    bit            force_en = 1'b0;
    logic [N-1:0]  force_vo = '0;
    logic [N-1:0]  pv [LAT];
    logic [N*DW-1:0] px [LAT];
    logic [N*DW-1:0] wmem [N];
    int            wl_idx;

    always @(posedge clk) begin
        if (core_clr) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= '0;
                px[i] <= '0;
            end
            for (int i = 0; i < N; i++) wmem[i] <= '0;
            wl_idx <= 0;
        end else begin
            pv[0] <= core_valid_in;
            px[0] <= core_x_in;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
            end
            if (core_load_weight) begin
                wmem[wl_idx] <= core_x_in;
                wl_idx       <= (wl_idx == N - 1) ? 0 : wl_idx + 1;
            end
        end
    end

    always_comb begin
        core_y_out = '0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                core_y_out[j*AW +: AW] = core_y_out[j*AW +: AW]
                    + AW'(px[LAT-1][i*DW +: DW]) * AW'(wmem[i][j*DW +: DW]);
    end

    assign core_valid_out = force_en ? force_vo : pv[LAT-1];

    // ---------------- stimulus helpers and reference ----------------
    function automatic int wgen(input int mode, input int i, input int j);
        if (mode == 0) return (i == j) ? 1 : 0;
        return (i == j) ? 2 : ((j == i + 1) ? 1 : 0);
    endfunction

    function automatic logic [N*DW-1:0] wrow(input int mode, input int k);
        logic [N*DW-1:0] w = '0;
        for (int j = 0; j < N; j++) w[j*DW +: DW] = DW'(wgen(mode, k, j));
        return w;
    endfunction

    function automatic logic [N*DW-1:0] a_row(input int r);
        logic [N*DW-1:0] x = '0;
        for (int i = 0; i < N; i++) x[i*DW +: DW] = DW'(r * N + i + 1);
        return x;
    endfunction

    // Identity echoes the row; mode 1 gives y[j] = 2*x[j] + x[j-1].
    function automatic logic [RW-1:0] exp_row(input int mode, input logic [N*DW-1:0] x);
        logic [RW-1:0] r = '0;
        for (int j = 0; j < N; j++) begin
            if (mode == 0) r[j*AW +: AW] = AW'(x[j*DW +: DW]);
            else r[j*AW +: AW] = 2 * AW'(x[j*DW +: DW]) + ((j > 0) ? AW'(x[(j-1)*DW +: DW]) : '0);
        end
        return r;
    endfunction

    function automatic int exp_lat(input int m, input int stalls);
        return (m == 0) ? N + 1 : 1 + N + m + LAT + 2 + stalls;
    endfunction

    // ---------------- scoreboard ----------------
    logic [RW-1:0] sb_q [$];
    bit            sb_on = 1'b0;
    int            res_cnt = 0;

    always @(negedge clk) begin
        if (sb_on && res_valid) begin
            if (sb_q.size() == 0) check("sb_underflow", 1, 0);
            else check("res_row", res_data, sb_q.pop_front());
            res_cnt++;
        end
    end

    // Runs one job; k counts cycles after the start cycle. rst_at > 0 asserts
    // reset at that cycle, checks the outputs and abandons the job.
    task automatic run_job(input job_t j, input int rst_at);
        int w_idx = 0, a_idx = 0, done_k = -1, done_cnt = 0;
        int lw_cnt = 0, vi_cnt = 0, in_bad = 0;
        bit ar_seen = 1'b0;
        res_cnt = 0;
        @(negedge clk);
        start    = 1'b1;
        num_rows = CW'(j.m);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = j.glitch && (k == N + 2);
            if (start) num_rows = CW'(99);
            if (k == 1) check("start_resp", {busy, bus.w_ready, err}, 3'b110);
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (bus.a_ready) ar_seen = 1'b1;
            if (k == rst_at) begin
                rst_n = 1'b0;
                bus.w_valid = 1'b0;
                bus.a_valid = 1'b0;
                #1;
                check("reset_mid_drain", {busy, done, err, res_valid, bus.w_ready, bus.a_ready,
                      core_load_weight, |core_valid_in, |core_x_in, |res_data}, '0);
                sb_on = 1'b0;
                sb_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            bus.w_valid = (w_idx < N);
            bus.w_data  = wrow(j.wmode, w_idx);
            bus.a_valid = (a_idx < j.m) && !(j.stall && (k % 2 == 1));
            bus.a_data  = a_row(a_idx);
            #1;
            if (core_load_weight) begin
                lw_cnt++;
                if (core_x_in !== bus.w_data) in_bad++;
            end else if (core_valid_in == '1) begin
                vi_cnt++;
                if (core_x_in !== bus.a_data) in_bad++;
            end else if (core_valid_in != '0 || core_x_in != '0) begin
                in_bad++;
            end
            if (bus.w_valid && bus.w_ready) w_idx++;
            if (bus.a_valid && bus.a_ready) begin
                sb_q.push_back(exp_row(j.wmode, a_row(a_idx)));
                a_idx++;
            end
            if (done_k > 0 && k == done_k + 1) begin
                check("after_done", {busy, done}, 2'b00);
                break;
            end
        end
        bus.w_valid = 1'b0;
        bus.a_valid = 1'b0;
        start       = 1'b0;
        check("done_lat", done_k, j.lat);
        check("done_cnt", done_cnt, 1);
        check("lw_beats", lw_cnt, N);
        check("vi_beats", vi_cnt, j.m);
        check("core_in_bad", in_bad, 0);
        check("a_ready_seen", ar_seen, (j.m > 0));
        check("rows", res_cnt, j.m);
        check("sb_empty", sb_q.size(), 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("perf_cycles", perf_cycles, j.lat);
        check("perf_stalls", perf_stalls, j.stalls);
`endif
    endtask

    job_t jobs [5];
    job_t rj;

    initial begin
        jobs[0] = '{4, 0, 1'b0, 1'b0, exp_lat(4, 0), 0};  // identity, no stalls
        jobs[1] = '{4, 0, 1'b1, 1'b0, exp_lat(4, 4), 4};  // alternate bubbles
        jobs[2] = '{0, 0, 1'b0, 1'b0, exp_lat(0, 0), 0};  // weight preload only
        jobs[3] = '{4, 1, 1'b0, 1'b1, exp_lat(4, 0), 0};  // start pulsed in STREAM
        jobs[4] = '{3, 1, 1'b1, 1'b0, exp_lat(3, 3), 3};

        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, err, res_valid, bus.w_ready, bus.a_ready,
              core_load_weight, |core_valid_in, |core_x_in, |core_y_in, |res_data}, '0);
        rst_n    = 1'b1;
        core_clr = 1'b0;
        sb_on    = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_job(jobs[i], 0);
            repeat (2) @(negedge clk);
        end

        // One cycle of partial column valids sets the sticky error.
        @(negedge clk);
        force_en = 1'b1;
        force_vo = 8'h0F;
        @(negedge clk);
        force_en = 1'b0;
        check("err_set", {err, res_valid}, 2'b10);
        repeat (5) @(negedge clk);
        check("err_sticky", err, 1'b1);
        run_job(jobs[4], 0);  // its start must clear err
        repeat (2) @(negedge clk);

        // Reset mid-DRAIN, let stray core rows drain out while IDLE, rerun.
        rj = '{4, 0, 1'b0, 1'b0, 0, 0};
        run_job(rj, N + 4 + 3);
        repeat (40) @(negedge clk);
        sb_on = 1'b1;
        rj = '{2, 0, 1'b0, 1'b0, exp_lat(2, 0), 0};
        run_job(rj, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
